ones_frame_accumulator: RTL and testbench

//  Streaming successor of the single-word ones counter. Counts HIGH bits over a frame of

---
 rtl/ones_frame_accumulator.sv | 156 +++++++++++++++
 tb/tb_ones_frame_accumulator.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_frame_accumulator.sv
// Streaming ones counter: popcounts each accepted beat of a valid/ready frame, accumulates
// with saturation and presents one registered count/threshold result per frame until accepted.
module ones_frame_accumulator #(
    parameter int INPUT_FEATURES = 8,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [INPUT_FEATURES-1:0] in_data_i,
    input  logic                      in_last_i,
    input  logic [COUNT_WIDTH-1:0]    threshold_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [COUNT_WIDTH-1:0]    out_count_o,
    output logic                      out_above_o,
    output logic                      out_sat_o
);
    localparam int PC_WIDTH = $clog2(INPUT_FEATURES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                 state_reg;
    logic                   in_ready_reg;
    logic                   out_valid_reg;
    logic                   out_above_reg;
    logic                   out_sat_reg;
    logic [COUNT_WIDTH-1:0] out_count_reg;
    logic [COUNT_WIDTH-1:0] threshold_reg;

    logic                   s1_valid_reg;
    logic                   s1_first_reg;
    logic                   s1_last_reg;
    logic [PC_WIDTH-1:0]    s1_pc_reg;

    logic [COUNT_WIDTH-1:0] acc_reg;
    logic                   acc_sat_reg;
    logic                   s2_last_reg;

    logic                   beat_accept;
    logic [COUNT_WIDTH-1:0] acc_base;
    logic [COUNT_WIDTH:0]   acc_sum;
    logic                   acc_overflow;

    // Ripple popcount: each stage adds one feature bit to the running total.
    logic [PC_WIDTH-1:0] partial_sum [INPUT_FEATURES+1];

    assign partial_sum[0] = '0;

    generate
        for (genvar gi = 0; gi < INPUT_FEATURES; gi++) begin : g_popcount
            assign partial_sum[gi+1] = partial_sum[gi] + PC_WIDTH'(in_data_i[gi]);
        end
    endgenerate

    assign beat_accept = in_valid_i && in_ready_reg;

    // A first-beat tag restarts the sum from zero, so nothing leaks between frames.
    always_comb begin
        acc_base     = s1_first_reg ? '0 : acc_reg;
        acc_sum      = {1'b0, acc_base} + (COUNT_WIDTH + 1)'(s1_pc_reg);
        acc_overflow = acc_sum[COUNT_WIDTH];
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            s1_valid_reg <= 1'b0;
            s1_first_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_pc_reg    <= '0;
            acc_reg      <= '0;
            acc_sat_reg  <= 1'b0;
            s2_last_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= beat_accept;
            if (beat_accept) begin
                s1_first_reg <= (state_reg == IDLE);
                s1_last_reg  <= in_last_i;
                s1_pc_reg    <= partial_sum[INPUT_FEATURES];
            end
            s2_last_reg <= s1_valid_reg && s1_last_reg;
            if (s1_valid_reg) begin
                acc_reg     <= acc_overflow ? '1 : acc_sum[COUNT_WIDTH-1:0];
                acc_sat_reg <= (s1_first_reg ? 1'b0 : acc_sat_reg) | acc_overflow;
            end
        end
    end

    // Frame control; in_ready is registered so it stays low throughout reset.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_count_reg <= '0;
            out_above_reg <= 1'b0;
            out_sat_reg   <= 1'b0;
            threshold_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (beat_accept) begin
                        threshold_reg <= threshold_i;
                        if (in_last_i) begin
                            state_reg    <= DRAIN;
                            in_ready_reg <= 1'b0;
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (beat_accept && in_last_i) begin
                        state_reg    <= DRAIN;
                        in_ready_reg <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (s2_last_reg) begin
                        state_reg     <= HOLD;
                        out_valid_reg <= 1'b1;
                        out_count_reg <= acc_reg;
                        out_sat_reg   <= acc_sat_reg;
                        out_above_reg <= (acc_reg >= threshold_reg);
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_reg;
    assign out_valid_o = out_valid_reg;
    assign out_count_o = out_count_reg;
    assign out_above_o = out_above_reg;
    assign out_sat_o   = out_sat_reg;

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// Directed and randomized frames driven into a 16-bit and a 4-bit accumulator in lockstep,
// checked against a per-frame arithmetic model of count, saturation and threshold result.
module tb_ones_frame_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [7:0]  in_data;
    logic [15:0] threshold;

    logic        in_ready_w, out_valid_w, above_w, sat_w;
    logic [15:0] count_w;
    logic        in_ready_s, out_valid_s, above_s, sat_s;
    logic [3:0]  count_s;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame_q[$];

    always #5 clk = ~clk;

    ones_frame_accumulator #(.INPUT_FEATURES(8), .COUNT_WIDTH(16)) dut_w (
        .clock_i    (clk),
        .reset_i    (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_w),
        .in_data_i  (in_data),
        .in_last_i  (in_last),
        .threshold_i(threshold),
        .out_valid_o(out_valid_w),
        .out_ready_i(out_ready),
        .out_count_o(count_w),
        .out_above_o(above_w),
        .out_sat_o  (sat_w)
    );

    ones_frame_accumulator #(.INPUT_FEATURES(8), .COUNT_WIDTH(4)) dut_s (
        .clock_i    (clk),
        .reset_i    (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_s),
        .in_data_i  (in_data),
        .in_last_i  (in_last),
        .threshold_i(threshold[3:0]),
        .out_valid_o(out_valid_s),
        .out_ready_i(out_ready),
        .out_count_o(count_s),
        .out_above_o(above_s),
        .out_sat_o  (sat_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready_w"}, 32'(in_ready_w), 32'd0);
        chk({tag, "_in_ready_s"}, 32'(in_ready_s), 32'd0);
        chk({tag, "_out_valid_w"}, 32'(out_valid_w), 32'd0);
        chk({tag, "_out_valid_s"}, 32'(out_valid_s), 32'd0);
        chk({tag, "_count_w"}, 32'(count_w), 32'd0);
        chk({tag, "_count_s"}, 32'(count_s), 32'd0);
        chk({tag, "_above_w"}, 32'(above_w), 32'd0);
        chk({tag, "_sat_w"}, 32'(sat_w), 32'd0);
        chk({tag, "_sat_s"}, 32'(sat_s), 32'd0);
    endtask

    // Offer one beat after 'gap' idle cycles; returns one tick after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic l, input logic [15:0] t, input int gap);
        int n;
        repeat (gap) begin
            in_valid  = 1'b0;
            in_data   = 8'($urandom);
            in_last   = 1'($urandom);
            threshold = 16'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = l;
        threshold = t;
        n = 0;
        while (in_ready_w !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("beat_in_ready_w", 32'(in_ready_w), 32'd1);
        chk("beat_in_ready_s", 32'(in_ready_s), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic collect(input int raw, input logic [15:0] thr, input int stall, input string tag);
        int lat;
        int ew, es;
        logic sw, ss, aw, as_;
        out_ready = 1'b0;
        lat = 0;
        while (out_valid_w !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 32'd2);
        chk({tag, "_valid_s"}, 32'(out_valid_s), 32'd1);
        ew  = (raw > 65535) ? 65535 : raw;
        sw  = (raw > 65535);
        es  = (raw > 15) ? 15 : raw;
        ss  = (raw > 15);
        aw  = (ew >= int'(thr));
        as_ = (es >= int'(thr & 16'h000F));
        chk({tag, "_count_w"}, 32'(count_w), ew);
        chk({tag, "_count_s"}, 32'(count_s), es);
        chk({tag, "_sat_w"}, 32'(sat_w), 32'(sw));
        chk({tag, "_sat_s"}, 32'(sat_s), 32'(ss));
        chk({tag, "_above_w"}, 32'(above_w), 32'(aw));
        chk({tag, "_above_s"}, 32'(above_s), 32'(as_));
        chk({tag, "_hold_ready"}, 32'(in_ready_w), 32'd0);
        // Offer junk beats while stalled: none may be taken, result must not move.
        repeat (stall) begin
            in_valid  = 1'b1;
            in_data   = 8'($urandom);
            in_last   = 1'($urandom);
            threshold = 16'($urandom);
            @(posedge clk);
            #1;
            chk({tag, "_stall_valid"}, 32'(out_valid_w), 32'd1);
            chk({tag, "_stall_count_w"}, 32'(count_w), ew);
            chk({tag, "_stall_count_s"}, 32'(count_s), es);
            chk({tag, "_stall_ready"}, 32'(in_ready_w), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_drop_valid_w"}, 32'(out_valid_w), 32'd0);
        chk({tag, "_drop_valid_s"}, 32'(out_valid_s), 32'd0);
        chk({tag, "_idle_ready_w"}, 32'(in_ready_w), 32'd1);
        chk({tag, "_idle_ready_s"}, 32'(in_ready_s), 32'd1);
        $display("frame %s: beats=%0d raw=%0d thr=%0d count_w=%0d count_s=%0d", tag, frame_q.size(), raw, thr, count_w, count_s);
    endtask

    task automatic run_frame(input logic [15:0] thr, input int later_thr, input int gap_max, input int stall, input string tag);
        int raw;
        int nb;
        logic [15:0] t;
        raw = 0;
        nb  = frame_q.size();
        for (int i = 0; i < nb; i++) begin
            if (i == 0) t = thr;
            else if (later_thr < 0) t = 16'($urandom);
            else t = 16'(later_thr);
            send_beat(frame_q[i], (i == nb - 1), t, int'($urandom_range(gap_max, 0)));
            raw += $countones(frame_q[i]);
        end
        collect(raw, thr, stall, tag);
    endtask

    initial begin
        int nb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        threshold = 16'h0000;
        out_ready = 1'b0;

        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_ready", 32'(in_ready_w), 32'd1);

        // Reset mid-frame after two of four beats.
        send_beat(8'hFF, 1'b0, 16'd0, 0);
        send_beat(8'hFF, 1'b0, 16'd0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midframe_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        frame_q = '{8'hFF, 8'h01};
        run_frame(16'd9, -1, 0, 0, "after_rst");

        // Reset while a result is being held.
        send_beat(8'h0F, 1'b1, 16'd1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_before_rst", 32'(out_valid_w), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("hold_rst");
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        frame_q = '{8'hF0, 8'h0F, 8'h03};
        run_frame(16'd10, -1, 0, 0, "basic");

        frame_q = '{8'hAA, 8'h55, 8'h01};
        run_frame(16'd3, -1, 0, 5, "backpressure");
        frame_q = '{8'h80};
        run_frame(16'd2, -1, 0, 0, "after_bp");

        frame_q = '{8'hFF, 8'hFF};
        run_frame(16'd20, -1, 0, 0, "sat_narrow");
        frame_q = '{8'h01};
        run_frame(16'd1, -1, 0, 0, "sat_cleared");

        frame_q = '{8'h03, 8'h03};
        run_frame(16'd5, 0, 0, 0, "thr_sampled");

        frame_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_frame(16'd40, -1, 3, 2, "gaps");

        // Wide accumulator: exactly full, then one past full.
        frame_q.delete();
        for (int i = 0; i < 8191; i++) frame_q.push_back(8'hFF);
        frame_q.push_back(8'h7F);
        run_frame(16'hFFFF, -1, 0, 0, "wide_full");
        frame_q.delete();
        for (int i = 0; i < 8192; i++) frame_q.push_back(8'hFF);
        run_frame(16'hFFFF, -1, 0, 0, "wide_sat");

        for (int f = 0; f < 1000; f++) begin
            nb = int'($urandom_range(6, 1));
            frame_q.delete();
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(9, 0) == 0) frame_q.push_back(8'hFF);
                else frame_q.push_back(8'($urandom));
            end
            run_frame(16'($urandom_range(40, 0)), -1, 2, int'($urandom_range(3, 0)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
